// File: rtl/fifo_rd_drain.sv
// fifo_rd_drain
// Read-side consumer for the asynchronous FIFO, entirely in the rclk domain.
// Pops words through the FIFO read port and absorbs the one-cycle read
// latency of the FIFO memory in a 3-entry skid buffer. Words leave on a
// valid/ready stream in pop order.
//
// Ports:
//   rclk, r_rst_n      read clock, asynchronous active-low reset
//   enable             allows new FIFO reads when high
//   empty, data_out    FIFO read-side flag and data (data one cycle after pop)
//   r_en               FIFO pop strobe
//   m_data, m_valid,   downstream stream
//   m_ready
//   rd_count           beats accepted downstream (wraps)
//   stall_count        cycles with m_valid=1 and m_ready=0 (wraps)
module fifo_rd_drain #(
    parameter int data_width = 8,
    parameter int cnt_width  = 16
) (
    input  logic                  rclk,
    input  logic                  r_rst_n,
    input  logic                  enable,
    input  logic                  empty,
    input  logic [data_width-1:0] data_out,
    output logic                  r_en,
    output logic [data_width-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [cnt_width-1:0]  rd_count,
    output logic [cnt_width-1:0]  stall_count
);

    logic [data_width-1:0] skid [0:2];
    logic [1:0]            wr_idx;
    logic [1:0]            rd_idx;
    logic [1:0]            occ;
    logic                  infl;
    logic [2:0]            pending;
    logic                  capture;
    logic                  xfer;

    // Advance a buffer index modulo 3.
    function automatic logic [1:0] wrap_inc(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    // Words already held plus the one arriving next cycle; a pop is only
    // issued when a slot is guaranteed for it, so m_ready never feeds r_en.
    assign pending = {1'b0, occ} + {2'b00, infl};
    assign r_en    = enable & ~empty & (pending < 3'd3);

    // data_out is valid exactly in the cycle after a pop.
    assign capture = infl;
    assign m_valid = (occ != 2'd0);
    assign m_data  = skid[rd_idx];
    assign xfer    = m_valid & m_ready;

    always_ff @(posedge rclk or negedge r_rst_n) begin
        if (!r_rst_n) begin
            for (int i = 0; i < 3; i++) begin
                skid[i] <= '0;
            end
            wr_idx      <= 2'd0;
            rd_idx      <= 2'd0;
            occ         <= 2'd0;
            infl        <= 1'b0;
            rd_count    <= '0;
            stall_count <= '0;
        end else begin
            infl <= r_en;

            if (capture) begin
                skid[wr_idx] <= data_out;
                wr_idx       <= wrap_inc(wr_idx);
            end

            if (xfer) begin
                rd_idx   <= wrap_inc(rd_idx);
                rd_count <= rd_count + cnt_width'(1);
            end

            if (m_valid && !m_ready) begin
                stall_count <= stall_count + cnt_width'(1);
            end

            case ({capture, xfer})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

endmodule
